// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR block: CSR addresses, field
// bit positions and the mstatus storage type.
package csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIP_MTIP_BIT     = 7;

  typedef struct packed {
    logic mpie;
    logic mie;
  } csr_mstatus_t;

  function automatic logic [31:0] csr_align4(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

  // MPP is hardwired to machine mode, so it always reads back as 2'b11.
  function automatic logic [31:0] csr_mstatus_pack(input csr_mstatus_t s);
    logic [31:0] r;
    r = 32'h0000_1800;
    r[MSTATUS_MIE_BIT]  = s.mie;
    r[MSTATUS_MPIE_BIT] = s.mpie;
    return r;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access port between the execute-stage CSR controller (master) and the
// CSR register file (slave).
interface csr_regfile_if;
  logic [31:0] csr_addr_i;
  logic        csr_read_i;
  logic        csr_write_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_addr_i, csr_read_i, csr_write_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_addr_i, csr_read_i, csr_write_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_d;
  logic [63:0] cnt_q;

  // Next count: direct write takes precedence over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) begin
        cnt_d[31:0] = wdata_i;
      end else begin
        cnt_d[31:0] = cnt_q[31:0];
      end
      if (wr_hi_i) begin
        cnt_d[63:32] = wdata_i;
      end else begin
        cnt_d[63:32] = cnt_q[63:32];
      end
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage and responder: address decode, zero-latency reads,
// edge-committed writes, trap entry/return, counters and timer-IRQ pending.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  csr_regfile_if.slave       csr,
  input  logic               exception_i,
  input  logic [31:0]        exc_cause_i,
  input  logic [31:0]        exc_pc_i,
  input  logic [31:0]        exc_tval_i,
  input  logic               mret_i,
  input  logic               instr_retire_i,
  input  logic               irq_timer_i,
  output logic [31:0]        mtvec_o,
  output logic [31:0]        mepc_o,
  output logic               irq_pending_o
);

  csr_mstatus_t mstatus_d, mstatus_q;
  logic         mtie_d, mtie_q;
  logic [31:0]  mtvec_d, mtvec_q;
  logic [31:0]  mscratch_d, mscratch_q;
  logic [31:0]  mepc_d, mepc_q;
  logic [31:0]  mcause_d, mcause_q;
  logic [31:0]  mtval_d, mtval_q;
  logic [63:0]  mcycle_s, minstret_s;

  logic [11:0]  addr_s;
  logic         impl_s;
  logic         ro_s;
  logic         illegal_s;
  logic         wr_ok_s;
  logic [31:0]  rdata_s;

  assign addr_s = csr.csr_addr_i[11:0];

  // Address decode and read mux; unimplemented addresses read as zero.
  always_comb begin
    impl_s  = 1'b1;
    rdata_s = 32'd0;
    case (addr_s)
      CSR_MSTATUS:   rdata_s = csr_mstatus_pack(mstatus_q);
      CSR_MISA:      rdata_s = MISA_VAL;
      CSR_MIE:       rdata_s[MIE_MTIE_BIT] = mtie_q;
      CSR_MTVEC:     rdata_s = mtvec_q;
      CSR_MSCRATCH:  rdata_s = mscratch_q;
      CSR_MEPC:      rdata_s = mepc_q;
      CSR_MCAUSE:    rdata_s = mcause_q;
      CSR_MTVAL:     rdata_s = mtval_q;
      CSR_MIP:       rdata_s[MIP_MTIP_BIT] = irq_timer_i;
      CSR_MCYCLE:    rdata_s = mcycle_s[31:0];
      CSR_MCYCLEH:   rdata_s = mcycle_s[63:32];
      CSR_MINSTRET:  rdata_s = minstret_s[31:0];
      CSR_MINSTRETH: rdata_s = minstret_s[63:32];
      CSR_MHARTID:   rdata_s = HART_ID;
      default: begin
        impl_s  = 1'b0;
        rdata_s = 32'd0;
      end
    endcase
    if (csr.csr_addr_i[31:12] != 20'd0) begin
      impl_s  = 1'b0;
      rdata_s = 32'd0;
    end else begin
      impl_s  = impl_s;
    end
  end

  assign ro_s      = (addr_s[11:10] == 2'b11) || (addr_s == CSR_MIP);
  assign illegal_s = (csr.csr_read_i || csr.csr_write_i) &&
                     (!impl_s || (csr.csr_write_i && ro_s));
  assign wr_ok_s   = csr.csr_write_i && !illegal_s;

  assign csr.csr_rdata_o   = rdata_s;
  assign csr.csr_illegal_o = illegal_s;

  // Next state: trap entry beats mret, which beats a CSR write to the
  // trap-owned registers; other CSRs accept writes regardless.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (exception_i) begin
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
      mepc_d         = csr_align4(exc_pc_i);
      mcause_d       = exc_cause_i;
      mtval_d        = exc_tval_i;
    end else if (mret_i) begin
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
    end else if (wr_ok_s) begin
      case (addr_s)
        CSR_MSTATUS: begin
          mstatus_d.mie  = csr.csr_wdata_i[MSTATUS_MIE_BIT];
          mstatus_d.mpie = csr.csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MEPC:   mepc_d   = csr_align4(csr.csr_wdata_i);
        CSR_MCAUSE: mcause_d = csr.csr_wdata_i;
        CSR_MTVAL:  mtval_d  = csr.csr_wdata_i;
        default:    mstatus_d = mstatus_q;
      endcase
    end else begin
      mstatus_d = mstatus_q;
    end

    if (wr_ok_s) begin
      case (addr_s)
        CSR_MIE:      mtie_d     = csr.csr_wdata_i[MIE_MTIE_BIT];
        CSR_MTVEC:    mtvec_d    = csr_align4(csr.csr_wdata_i);
        CSR_MSCRATCH: mscratch_d = csr.csr_wdata_i;
        default:      mtie_d     = mtie_q;
      endcase
    end else begin
      mtie_d = mtie_q;
    end
  end

  // CSR state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_q  <= '{mpie: 1'b0, mie: 1'b0};
      mtie_q     <= 1'b0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (wr_ok_s && (addr_s == CSR_MCYCLE)),
    .wr_hi_i (wr_ok_s && (addr_s == CSR_MCYCLEH)),
    .wdata_i (csr.csr_wdata_i),
    .cnt_o   (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instr_retire_i),
    .wr_lo_i (wr_ok_s && (addr_s == CSR_MINSTRET)),
    .wr_hi_i (wr_ok_s && (addr_s == CSR_MINSTRETH)),
    .wdata_i (csr.csr_wdata_i),
    .cnt_o   (minstret_s)
  );

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = mstatus_q.mie && mtie_q && irq_timer_i;

endmodule
